iccm_prog_ctrl: RTL and testbench

Boot-time program loader that drives the ICCM controller write interface of the instruction memory. It assembles a byte stream from the UART receiver into 32-bit little-endian words and writes them to consecutive ICCM word addresses. It holds the core in program reset (prog_rst_no low) until an end-of-program marker arrives or the address space is exhausted, then releases the core.

---
 rtl/iccm_prog_ctrl_if.sv | 19 +
 rtl/iccm_prog_ctrl.sv | 68 ++++++
 tb/tb_iccm_prog_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/iccm_prog_ctrl_if.sv
// iccm_prog_ctrl_if: UART byte input and ICCM write/status bundle for the boot program loader
interface iccm_prog_ctrl_if #(parameter int AddrW = 12);
  logic [7:0]       rx_byte_i;
  logic             rx_valid_i;
  logic [AddrW-1:0] iccm_ctrl_addr_o;
  logic [31:0]      iccm_ctrl_wdata_o;
  logic             iccm_ctrl_we_o;
  logic             prog_rst_no;
  logic             done_o;
  logic             overflow_o;
  modport master (
    input  rx_byte_i, rx_valid_i,
    output iccm_ctrl_addr_o, iccm_ctrl_wdata_o, iccm_ctrl_we_o, prog_rst_no, done_o, overflow_o
  );
  modport slave (
    output rx_byte_i, rx_valid_i,
    input  iccm_ctrl_addr_o, iccm_ctrl_wdata_o, iccm_ctrl_we_o, prog_rst_no, done_o, overflow_o
  );
endinterface

// File: rtl/iccm_prog_ctrl.sv
// iccm_prog_ctrl: packs UART bytes into little-endian words and writes them to ICCM until end marker or full
module iccm_prog_ctrl #(
  parameter int          AddrW   = 12,
  parameter logic [31:0] EndWord = 32'h0000_0FFF
) (
  input logic            clk_i,
  input logic            rst_ni,
  iccm_prog_ctrl_if.master bus
);
  typedef enum logic [1:0] {LOAD, WRITE, DONE} state_t;
  localparam logic [AddrW-1:0] LastAddr = '1;
  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] lanes;
  logic [31:0] word;
  assign word = {bus.rx_byte_i, lanes};
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state                 <= LOAD;
      byte_cnt              <= '0;
      lanes                 <= '0;
      bus.iccm_ctrl_addr_o  <= '0;
      bus.iccm_ctrl_wdata_o <= '0;
      bus.iccm_ctrl_we_o    <= 1'b0;
      bus.prog_rst_no       <= 1'b0;
      bus.done_o            <= 1'b0;
      bus.overflow_o        <= 1'b0;
    end else begin
      case (state)
        LOAD: if (bus.rx_valid_i) begin
          if (byte_cnt == 2'd3) begin
            byte_cnt              <= '0;
            bus.iccm_ctrl_wdata_o <= word;
            if (word == EndWord) begin
              state           <= DONE;
              bus.prog_rst_no <= 1'b1;
              bus.done_o      <= 1'b1;
            end else begin
              state              <= WRITE;
              bus.iccm_ctrl_we_o <= 1'b1;
            end
          end else begin
            lanes[{byte_cnt, 3'b000} +: 8] <= bus.rx_byte_i;
            byte_cnt                       <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          bus.iccm_ctrl_we_o   <= 1'b0;
          bus.iccm_ctrl_addr_o <= bus.iccm_ctrl_addr_o + 1'b1;
          // a byte landing during the write cycle starts the next word
          if (bus.rx_valid_i) begin
            lanes[7:0] <= bus.rx_byte_i;
            byte_cnt   <= 2'd1;
          end
          if (bus.iccm_ctrl_addr_o == LastAddr) begin
            state           <= DONE;
            bus.overflow_o  <= 1'b1;
            bus.prog_rst_no <= 1'b1;
            bus.done_o      <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_iccm_prog_ctrl.sv
// tb_iccm_prog_ctrl: directed self-checking bench for the ICCM boot program loader
module tb_iccm_prog_ctrl;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int total = 0;
  int passed = 0;
  iccm_prog_ctrl_if #(.AddrW(12)) bus ();
  iccm_prog_ctrl #(.AddrW(12), .EndWord(32'h0000_0FFF)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte_i  = b;
    bus.rx_valid_i = 1'b1;
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(bus.iccm_ctrl_addr_o), 32'h0);
    chk({tag, "_wdata"}, bus.iccm_ctrl_wdata_o, 32'h0);
    chk({tag, "_we"}, 32'(bus.iccm_ctrl_we_o), 32'h0);
    chk({tag, "_prst"}, 32'(bus.prog_rst_no), 32'h0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'h0);
    chk({tag, "_ovf"}, 32'(bus.overflow_o), 32'h0);
  endtask
  task automatic do_reset();
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask
  initial begin
    bus.rx_byte_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst_ni = 1'b1;
    // single word 0x00000513 at address 0
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    chk("w0_we", 32'(bus.iccm_ctrl_we_o), 32'h1);
    chk("w0_addr", 32'(bus.iccm_ctrl_addr_o), 32'h000);
    chk("w0_wdata", bus.iccm_ctrl_wdata_o, 32'h0000_0513);
    chk("w0_prst", 32'(bus.prog_rst_no), 32'h0);
    idle(1);
    chk("w0_we_off", 32'(bus.iccm_ctrl_we_o), 32'h0);
    chk("w0_addr_inc", 32'(bus.iccm_ctrl_addr_o), 32'h001);
    chk("w0_prst2", 32'(bus.prog_rst_no), 32'h0);
    // second word with a gap, third word back-to-back (first byte during WRITE)
    send_word(32'hAABB_CCDD);
    chk("w1_we", 32'(bus.iccm_ctrl_we_o), 32'h1);
    chk("w1_addr", 32'(bus.iccm_ctrl_addr_o), 32'h001);
    chk("w1_wdata", bus.iccm_ctrl_wdata_o, 32'hAABB_CCDD);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    chk("w2_we", 32'(bus.iccm_ctrl_we_o), 32'h1);
    chk("w2_addr", 32'(bus.iccm_ctrl_addr_o), 32'h002);
    chk("w2_wdata", bus.iccm_ctrl_wdata_o, 32'h1122_3344);
    send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h00); send_byte(8'h00);
    chk("end_we", 32'(bus.iccm_ctrl_we_o), 32'h0);
    chk("end_done", 32'(bus.done_o), 32'h1);
    chk("end_prst", 32'(bus.prog_rst_no), 32'h1);
    chk("end_addr", 32'(bus.iccm_ctrl_addr_o), 32'h003);
    chk("end_ovf", 32'(bus.overflow_o), 32'h0);
    // DONE ignores further bytes
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'h10 + i));
      chk("done_we", 32'(bus.iccm_ctrl_we_o), 32'h0);
    end
    chk("done_addr", 32'(bus.iccm_ctrl_addr_o), 32'h003);
    chk("done_wdata", bus.iccm_ctrl_wdata_o, 32'h0000_0FFF);
    chk("done_done", 32'(bus.done_o), 32'h1);
    chk("done_prst", 32'(bus.prog_rst_no), 32'h1);
    // end marker as the very first word
    do_reset();
    send_word(32'h0000_0FFF);
    chk("first_end_done", 32'(bus.done_o), 32'h1);
    chk("first_end_addr", 32'(bus.iccm_ctrl_addr_o), 32'h000);
    chk("first_end_we", 32'(bus.iccm_ctrl_we_o), 32'h0);
    chk("first_end_ovf", 32'(bus.overflow_o), 32'h0);
    // reset in the middle of word 5 discards the partial word
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_word(32'h5000_0000 + 32'(i));
      chk("mid_addr", 32'(bus.iccm_ctrl_addr_o), 32'(i));
    end
    send_byte(8'hEE); send_byte(8'hDD);
    rst_ni = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    rst_ni = 1'b1;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("mid_we", 32'(bus.iccm_ctrl_we_o), 32'h1);
    chk("mid_addr0", 32'(bus.iccm_ctrl_addr_o), 32'h000);
    chk("mid_wdata", bus.iccm_ctrl_wdata_o, 32'h0403_0201);
    // fill all 4096 words with bytes every cycle
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      send_word({16'hA5A5, 16'(i)});
      if (i == 0 || i == 2047 || i == 4095) begin
        chk("ovf_we", 32'(bus.iccm_ctrl_we_o), 32'h1);
        chk("ovf_addr", 32'(bus.iccm_ctrl_addr_o), 32'(i));
        chk("ovf_wdata", bus.iccm_ctrl_wdata_o, {16'hA5A5, 16'(i)});
      end
      if (i == 4094) chk("ovf_not_yet", 32'(bus.overflow_o), 32'h0);
    end
    idle(1);
    chk("ovf_flag", 32'(bus.overflow_o), 32'h1);
    chk("ovf_done", 32'(bus.done_o), 32'h1);
    chk("ovf_prst", 32'(bus.prog_rst_no), 32'h1);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h77);
      chk("ovf_no_we", 32'(bus.iccm_ctrl_we_o), 32'h0);
    end
    chk("ovf_sticky", 32'(bus.overflow_o), 32'h1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
